// File: rtl/alu_exec.sv
// Multi-cycle ALU: reads two operands from an external register file, executes, writes back.
// Optional define ALU_EXEC_FLAGS_EN adds registered zero/carry flag outputs.
module alu_exec #(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          op_valid,
    output logic          op_ready,
    input  logic [2:0]    opcode,
    input  logic [AW-1:0] rd,
    input  logic [AW-1:0] rs1,
    input  logic [AW-1:0] rs2,
    output logic [AW-1:0] rf_addr_r,
    input  logic [DW-1:0] rf_data,
    output logic          rf_we,
    output logic [AW-1:0] rf_addr_w,
    output logic [DW-1:0] rf_wdata,
    output logic          done,
    output logic [DW-1:0] result
`ifdef ALU_EXEC_FLAGS_EN
    ,
    output logic          flag_z,
    output logic          flag_c
`endif
);

    typedef enum logic [2:0] {IDLE, RDA, RDB, EXE, WB} state_e;
    typedef enum logic [2:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR, OP_MOV
    } alu_op_e;

    state_e          state, state_nxt;
    alu_op_e         opcode_q;
    logic [AW-1:0]   rd_q, rs1_q, rs2_q;
    logic [DW-1:0]   op_a, op_b;
    logic [DW-1:0]   alu_res;

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            opcode_q <= OP_ADD;
            rd_q     <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            op_a     <= '0;
            op_b     <= '0;
            result   <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (op_valid) begin
                    opcode_q <= alu_op_e'(opcode);
                    rd_q     <= rd;
                    rs1_q    <= rs1;
                    rs2_q    <= rs2;
                end
                RDA:     op_a   <= rf_data;
                RDB:     op_b   <= rf_data;
                EXE:     result <= alu_res;
                default: ;
            endcase
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        op_ready  = 1'b0;
        rf_addr_r = '0;
        rf_we     = 1'b0;
        rf_addr_w = '0;
        rf_wdata  = '0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                op_ready = 1'b1;
                if (op_valid) state_nxt = RDA;
            end
            RDA: begin
                rf_addr_r = rs1_q;
                state_nxt = RDB;
            end
            RDB: begin
                rf_addr_r = rs2_q;
                state_nxt = EXE;
            end
            EXE: state_nxt = WB;
            WB: begin
                rf_we     = 1'b1;
                rf_addr_w = rd_q;
                rf_wdata  = result;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        alu_res = '0;
        case (opcode_q)
            OP_ADD: alu_res = op_a + op_b;
            OP_SUB: alu_res = op_a - op_b;
            OP_AND: alu_res = op_a & op_b;
            OP_OR:  alu_res = op_a | op_b;
            OP_XOR: alu_res = op_a ^ op_b;
            OP_SHL: alu_res = {op_a[DW-2:0], 1'b0};
            OP_SHR: alu_res = {1'b0, op_a[DW-1:1]};
            OP_MOV: alu_res = op_a;
            default: alu_res = '0;
        endcase
    end

`ifdef ALU_EXEC_FLAGS_EN
    logic [DW:0] ext_sum, ext_diff;
    logic        alu_c;

    assign ext_sum  = {1'b0, op_a} + {1'b0, op_b};
    assign ext_diff = {1'b0, op_a} - {1'b0, op_b};

    // Carry is the 9th sum bit for ADD, the borrow for SUB, and the shifted-out bit for shifts.
    always_comb begin
        alu_c = 1'b0;
        case (opcode_q)
            OP_ADD:  alu_c = ext_sum[DW];
            OP_SUB:  alu_c = ext_diff[DW];
            OP_SHL:  alu_c = op_a[DW-1];
            OP_SHR:  alu_c = op_a[0];
            default: alu_c = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_z <= 1'b0;
            flag_c <= 1'b0;
        end else if (state == EXE) begin
            flag_z <= (alu_res == '0);
            flag_c <= alu_c;
        end
    end
`endif

endmodule

// File: tb/tb_alu_exec.sv
// Self-checking bench for alu_exec: table-driven opcode vectors plus latency, back-to-back and reset sequences.
// Flag checks are compiled in when ALU_EXEC_FLAGS_EN is defined.
module tb_alu_exec;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       op_valid;
    logic       op_ready;
    logic [2:0] opcode;
    logic [3:0] rd, rs1, rs2;
    logic [3:0] rf_addr_r;
    logic [7:0] rf_data;
    logic       rf_we;
    logic [3:0] rf_addr_w;
    logic [7:0] rf_wdata;
    logic       done;
    logic [7:0] result;
`ifdef ALU_EXEC_FLAGS_EN
    logic       flag_z, flag_c;
`endif

    always #5 clk = ~clk;

    alu_exec #(.DW(8), .AW(4)) dut (
        .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready),
        .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
        .rf_addr_r(rf_addr_r), .rf_data(rf_data),
        .rf_we(rf_we), .rf_addr_w(rf_addr_w), .rf_wdata(rf_wdata),
        .done(done), .result(result)
`ifdef ALU_EXEC_FLAGS_EN
        , .flag_z(flag_z), .flag_c(flag_c)
`endif
    );

    // Behavioural register file with a preload port used only while the DUT is idle.
    logic [7:0] regs [16];
    logic       pl_en = 1'b0;
    logic [3:0] pl_addr = '0;
    logic [7:0] pl_data = '0;
    assign rf_data = regs[rf_addr_r];

    always @(posedge clk) begin
        if (rf_we)      regs[rf_addr_w] <= rf_wdata;
        else if (pl_en) regs[pl_addr]   <= pl_data;
    end

    int we_count = 0;
    always @(posedge clk) if (rf_we) we_count <= we_count + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    // Issues one op and checks the cycle-exact sequence: RDA, RDB, EXE, WB, then back to IDLE.
    task automatic run_op(input string name, input logic [2:0] op, input logic [3:0] d,
                          input logic [3:0] s1, input logic [3:0] s2, input logic [7:0] exp);
        @(negedge clk);
        op_valid = 1'b1; opcode = op; rd = d; rs1 = s1; rs2 = s2;
        @(negedge clk);
        op_valid = 1'b0; opcode = 3'b000; rd = '0; rs1 = '0; rs2 = '0;
        check({name, " rda addr"}, {28'd0, rf_addr_r}, {28'd0, s1});
        check({name, " rda ready"}, {31'd0, op_ready}, 32'd0);
        @(negedge clk);
        check({name, " rdb addr"}, {28'd0, rf_addr_r}, {28'd0, s2});
        @(negedge clk);
        check({name, " exe done"}, {31'd0, done}, 32'd0);
        @(negedge clk);
        check({name, " wb done"}, {31'd0, done}, 32'd1);
        check({name, " wb we"}, {31'd0, rf_we}, 32'd1);
        check({name, " wb addr"}, {28'd0, rf_addr_w}, {28'd0, d});
        check({name, " wb data"}, {24'd0, rf_wdata}, {24'd0, exp});
        @(negedge clk);
        check({name, " post done"}, {31'd0, done}, 32'd0);
        check({name, " post ready"}, {31'd0, op_ready}, 32'd1);
        check({name, " result"}, {24'd0, result}, {24'd0, exp});
        check({name, " reg"}, {24'd0, regs[d]}, {24'd0, exp});
    endtask

    typedef struct {
        string      name;
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic       z;
        logic       c;
    } vec_t;

    vec_t vecs [12];

    initial begin
        vecs[0]  = '{"add 05+03",  3'b000, 8'h05, 8'h03, 8'h08, 1'b0, 1'b0};
        vecs[1]  = '{"add ff+01",  3'b000, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1};
        vecs[2]  = '{"sub 01-ff",  3'b001, 8'h01, 8'hFF, 8'h02, 1'b0, 1'b1};
        vecs[3]  = '{"sub 05-05",  3'b001, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0};
        vecs[4]  = '{"and",        3'b010, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0};
        vecs[5]  = '{"or",         3'b011, 8'hF0, 8'h0F, 8'hFF, 1'b0, 1'b0};
        vecs[6]  = '{"xor",        3'b100, 8'hAA, 8'hFF, 8'h55, 1'b0, 1'b0};
        vecs[7]  = '{"shl 81",     3'b101, 8'h81, 8'h00, 8'h02, 1'b0, 1'b1};
        vecs[8]  = '{"shr 81",     3'b110, 8'h81, 8'hFF, 8'h40, 1'b0, 1'b1};
        vecs[9]  = '{"mov",        3'b111, 8'h7E, 8'h11, 8'h7E, 1'b0, 1'b0};
        vecs[10] = '{"shl 40",     3'b101, 8'h40, 8'hFF, 8'h80, 1'b0, 1'b0};
        vecs[11] = '{"shr 00",     3'b110, 8'h00, 8'hFF, 8'h00, 1'b1, 1'b0};

        rst_n = 1'b0; op_valid = 1'b0; opcode = '0; rd = '0; rs1 = '0; rs2 = '0;
        #12;
        check("reset ready", {31'd0, op_ready}, 32'd1);
        check("reset we",    {31'd0, rf_we}, 32'd0);
        check("reset done",  {31'd0, done}, 32'd0);
        check("reset raddr", {28'd0, rf_addr_r}, 32'd0);
        check("reset waddr", {28'd0, rf_addr_w}, 32'd0);
        check("reset wdata", {24'd0, rf_wdata}, 32'd0);
        check("reset result", {24'd0, result}, 32'd0);
`ifdef ALU_EXEC_FLAGS_EN
        check("reset flag_z", {31'd0, flag_z}, 32'd0);
        check("reset flag_c", {31'd0, flag_c}, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Opcode table: r1=A, r2=B, op rd=3, rs1=1, rs2=2.
        for (int i = 0; i < 12; i++) begin
            preload(4'd1, vecs[i].a);
            preload(4'd2, vecs[i].b);
            preload(4'd3, 8'hA5);
            run_op(vecs[i].name, vecs[i].op, 4'd3, 4'd1, 4'd2, vecs[i].res);
`ifdef ALU_EXEC_FLAGS_EN
            check({vecs[i].name, " flag_z"}, {31'd0, flag_z}, {31'd0, vecs[i].z});
            check({vecs[i].name, " flag_c"}, {31'd0, flag_c}, {31'd0, vecs[i].c});
`endif
        end

        // Back-to-back: op_valid held high, ADD r1,r1,r1 twice from r1=05.
        begin
            int acc_cyc [2];
            int n_acc = 0;
            int low_cnt = 0;
            logic [7:0] r1_at_second = '0;
            preload(4'd1, 8'h05);
            @(negedge clk);
            op_valid = 1'b1; opcode = 3'b000; rd = 4'd1; rs1 = 4'd1; rs2 = 4'd1;
            for (int cyc = 0; cyc < 20; cyc++) begin
                if (cyc > 0) @(negedge clk);
                if (n_acc == 2) op_valid = 1'b0;
                if (op_valid && op_ready) begin
                    if (n_acc == 1) r1_at_second = regs[1];
                    acc_cyc[n_acc] = cyc;
                    n_acc++;
                end else if (n_acc == 1 && !op_ready) begin
                    low_cnt++;
                end
            end
            op_valid = 1'b0;
            check("b2b accepts", n_acc, 2);
            if (n_acc == 2) check("b2b spacing", acc_cyc[1] - acc_cyc[0], 5);
            check("b2b ready low", low_cnt, 4);
            check("b2b first write", {24'd0, r1_at_second}, 32'h0A);
            check("b2b second write", {24'd0, regs[1]}, 32'h14);
        end

        // Reset asserted mid-EXE of ADD rd=5 must abort the write.
        begin
            int we_before;
            preload(4'd1, 8'h05);
            preload(4'd2, 8'h03);
            preload(4'd5, 8'h33);
            we_before = we_count;
            @(negedge clk);
            op_valid = 1'b1; opcode = 3'b000; rd = 4'd5; rs1 = 4'd1; rs2 = 4'd2;
            @(negedge clk);
            op_valid = 1'b0;
            @(negedge clk);
            @(negedge clk);
            rst_n = 1'b0;
            #1;
            check("abort ready", {31'd0, op_ready}, 32'd1);
            check("abort we", {31'd0, rf_we}, 32'd0);
            check("abort result", {24'd0, result}, 32'd0);
`ifdef ALU_EXEC_FLAGS_EN
            check("abort flag_z", {31'd0, flag_z}, 32'd0);
`endif
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
            repeat (6) @(negedge clk);
            check("abort no write", we_count - we_before, 0);
            check("abort r5", {24'd0, regs[5]}, 32'h33);
            check("abort idle", {31'd0, op_ready}, 32'd1);
        end

        // Recovery after abort.
        run_op("post-abort add", 3'b000, 4'd6, 4'd1, 4'd2, 8'h08);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
